n_bit_chunk_adder: RTL

Parametrised multi-cycle adder/subtractor, the sequential successor of the team's combinational n-bit adder. It latches two N-bit operands on a start handshake and processes them W bits per clock, rippling the carry through a register. It returns an (N+1)-bit result with a one-cycle done pulse. It is intended for datapaths where a full-width carry chain does not meet timing, or where area must be traded for latency.

---
 rtl/n_bit_chunk_adder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/n_bit_chunk_adder.sv
// Multi-cycle N-bit adder/subtractor that ripples a registered carry through W-bit chunks.
// Optional signed-overflow output is enabled by defining N_BIT_CHUNK_ADDER_OVF_EN.
module n_bit_chunk_adder #(
  parameter int N = 8,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N:0]   sum
`ifdef N_BIT_CHUNK_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CHUNKS = N / W;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  generate
    if (N < 1 || W < 1 || (N % W) != 0) begin : g_bad_params
      $error("n_bit_chunk_adder: N must be >= 1 and a multiple of W");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e         state_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [CW-1:0]  cnt_q;
  logic           carry_q;
  logic [N:0]     sum_q;
  logic           busy_q;
  logic           done_q;

  logic [W-1:0]   aChunk;
  logic [W-1:0]   bChunk;
  logic [W-1:0]   chunkSum_d;
  logic           carry_d;
  logic           lastChunk;

  // Mux out the chunk selected by the counter; b_q is already inverted for subtraction.
  always_comb begin
    aChunk = '0;
    bChunk = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      if (cnt_q == CW'(i)) begin
        aChunk = a_q[i*W +: W];
        bChunk = b_q[i*W +: W];
      end
    end
    {carry_d, chunkSum_d} = {1'b0, aChunk} + {1'b0, bChunk} + {{W{1'b0}}, carry_q};
    lastChunk = (cnt_q == CW'(CHUNKS - 1));
  end

`ifdef N_BIT_CHUNK_ADDER_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // Carry into the chunk MSB is recovered from the MSB sum bit and its operand bits.
  always_comb begin
    ovf_d = aChunk[W-1] ^ bChunk[W-1] ^ chunkSum_d[W-1] ^ carry_d;
  end

  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef N_BIT_CHUNK_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        RUN: begin
          for (int i = 0; i < CHUNKS; i++) begin
            if (cnt_q == CW'(i)) begin
              sum_q[i*W +: W] <= chunkSum_d;
            end
          end
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (lastChunk) begin
            sum_q[N] <= carry_d;
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
`ifdef N_BIT_CHUNK_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
          end
        end
        // IDLE and DONE both accept a new request, giving back-to-back issue from DONE.
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            sum_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
`ifdef N_BIT_CHUNK_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;

endmodule
